// File: rtl/vita49_pkt_framer.sv
// Purpose: frames a 32-bit {I,Q} sample stream into VITA-49 IF-Data-with-Stream-ID packets on AXI-Stream.
// Latency: header word valid 1 cycle after a sample is offered in IDLE; payload is a combinational pass-through.
// Backpressure: header words hold until accepted; in payload s_axis_tready follows m_axis_tready directly.
//
// Ports:
//   ACLK, ARESETN                      clock, synchronous active-low reset
//   enable                             start new packets (dropping it lets the current packet finish)
//   stream_id, payload_len, tsi, tsf   captured on the edge a packet starts
//   s_axis_*                           sample input {I[15:0], Q[15:0]}
//   m_axis_*                           packet output (5 header words, then L payload words)
//   pkt_count, pkt_total               4-bit VITA-49 packet count, 32-bit completed packet counter
module vita49_pkt_framer #(
   parameter logic [1:0]  TSI_TYPE    = 2'b01,
   parameter logic [1:0]  TSF_TYPE    = 2'b01,
   parameter int unsigned MAX_PAYLOAD = 65530
) (
   input  logic        ACLK,
   input  logic        ARESETN,
   input  logic        enable,
   input  logic [31:0] stream_id,
   input  logic [15:0] payload_len,
   input  logic [31:0] tsi,
   input  logic [63:0] tsf,
   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic [3:0]  pkt_count,
   output logic [31:0] pkt_total
);

   localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_SID,
      S_TSI,
      S_TSFH,
      S_TSFL,
      S_PAY
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] sid_q, sid_d;
   logic [31:0] tsi_q, tsi_d;
   logic [63:0] tsf_q, tsf_d;
   logic [15:0] len_q, len_d;
   logic [15:0] wcnt_q, wcnt_d;
   logic [3:0]  pkt_count_q, pkt_count_d;
   logic [31:0] pkt_total_q, pkt_total_d;

   logic [15:0] eff_len;
   logic        last_word;

   // Zero-length requests still carry one sample so every packet has a tlast beat.
   always_comb begin
      if (payload_len == 16'd0) begin
         eff_len = 16'd1;
      end else if (payload_len > MAX_LEN) begin
         eff_len = MAX_LEN;
      end else begin
         eff_len = payload_len;
      end
   end

   // wcnt_q counts accepted payload words from 0, so the L-th word is at L-1.
   assign last_word = (wcnt_q == (len_q - 16'd1));

   always_comb begin
      state_d       = state_q;
      sid_d         = sid_q;
      tsi_d         = tsi_q;
      tsf_d         = tsf_q;
      len_d         = len_q;
      wcnt_d        = wcnt_q;
      pkt_count_d   = pkt_count_q;
      pkt_total_d   = pkt_total_q;
      m_axis_tdata  = 32'd0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      s_axis_tready = 1'b0;

      case (state_q)
         S_IDLE: begin
            // The first sample is only observed here, not consumed; it is
            // passed through once the header has gone out.
            if (enable && s_axis_tvalid) begin
               sid_d   = stream_id;
               tsi_d   = tsi;
               tsf_d   = tsf;
               len_d   = eff_len;
               wcnt_d  = 16'd0;
               state_d = S_HDR;
            end
         end
         S_HDR: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = {4'b0001, 4'b0000, TSI_TYPE, TSF_TYPE, pkt_count_q,
                             len_q + 16'd5};
            if (m_axis_tready) begin
               state_d = S_SID;
            end
         end
         S_SID: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = sid_q;
            if (m_axis_tready) begin
               state_d = S_TSI;
            end
         end
         S_TSI: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = tsi_q;
            if (m_axis_tready) begin
               state_d = S_TSFH;
            end
         end
         S_TSFH: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = tsf_q[63:32];
            if (m_axis_tready) begin
               state_d = S_TSFL;
            end
         end
         S_TSFL: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = tsf_q[31:0];
            if (m_axis_tready) begin
               state_d = S_PAY;
            end
         end
         S_PAY: begin
            m_axis_tdata  = s_axis_tdata;
            m_axis_tvalid = s_axis_tvalid;
            s_axis_tready = m_axis_tready;
            m_axis_tlast  = last_word;
            if (s_axis_tvalid && m_axis_tready) begin
               wcnt_d = wcnt_q + 16'd1;
               if (last_word) begin
                  pkt_count_d = pkt_count_q + 4'd1;
                  pkt_total_d = pkt_total_q + 32'd1;
                  state_d     = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state_q     <= S_IDLE;
         sid_q       <= 32'd0;
         tsi_q       <= 32'd0;
         tsf_q       <= 64'd0;
         len_q       <= 16'd0;
         wcnt_q      <= 16'd0;
         pkt_count_q <= 4'd0;
         pkt_total_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         sid_q       <= sid_d;
         tsi_q       <= tsi_d;
         tsf_q       <= tsf_d;
         len_q       <= len_d;
         wcnt_q      <= wcnt_d;
         pkt_count_q <= pkt_count_d;
         pkt_total_q <= pkt_total_d;
      end
   end

   assign pkt_count = pkt_count_q;
   assign pkt_total = pkt_total_q;

endmodule

// File: doc/vita49_pkt_framer.md
Name: vita49_pkt_framer

Overview:
- Downstream consumer of vita49_tsfclk_logic.
- Frames a continuous 32-bit I/Q sample stream into VITA-49 IF-Data-with-Stream-ID packets on AXI-Stream, 32-bit wide.
- Each packet carries the TSI/TSF values captured when the packet's first sample is presented.
- Sits between the ADC sample path / timestamp generator and the packet DMA.

Parameters:
- TSI_TYPE, 2'b01, header TSI field value (UTC).
- TSF_TYPE, 2'b01, header TSF field value (sample count).
- MAX_PAYLOAD, 65530, upper clamp on payload words per packet.

Ports:
- ACLK  in  1  sole clock; all inputs are synchronous to it, including tsi/tsf.
- ARESETN  in  1  synchronous, active-low reset.
- enable  in  1  1 = start new packets; 0 = finish the current packet, then idle.
- stream_id  in  32  sampled at packet start.
- payload_len  in  16  payload words per packet, sampled at packet start.
- tsi  in  32  integer timestamp from the timestamp generator.
- tsf  in  64  fractional timestamp from the timestamp generator.
- s_axis_tdata  in  32  sample {I[15:0], Q[15:0]}.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tready  out  1  sample accept.
- m_axis_tdata  out  32  packet word.
- m_axis_tvalid  out  1  packet word valid.
- m_axis_tready  in  1  downstream accept.
- m_axis_tlast  out  1  last word of packet.
- pkt_count  out  4  current VITA-49 packet count field.
- pkt_total  out  32  packets completed since reset.

Behaviour:
- Reset (ARESETN=0 at an ACLK edge), outputs:
  - state=IDLE.
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - pkt_count=0, pkt_total=0.
- Reset mid-packet aborts the packet immediately. No tlast is emitted for the partial packet.
- States: IDLE, HDR, SID, TSI, TSFH, TSFL, PAY.
- IDLE:
  - m_axis_tvalid=0, s_axis_tready=0.
  - If enable && s_axis_tvalid: at that edge latch tsi, tsf, stream_id and effective length L; next state HDR.
  - L = 1 if payload_len==0; MAX_PAYLOAD if payload_len>MAX_PAYLOAD; else payload_len.
- Header words are driven from registers with m_axis_tvalid=1 and s_axis_tready=0. Each advances on m_axis_tvalid && m_axis_tready:
  - HDR word, fields:
    - [31:28]=4'b0001, [27:24]=0.
    - [23:22]=TSI_TYPE, [21:20]=TSF_TYPE.
    - [19:16]=pkt_count.
    - [15:0]=L+5.
  - SID = latched stream_id.
  - TSI = latched tsi.
  - TSFH = latched tsf[63:32].
  - TSFL = latched tsf[31:0].
  - After TSFL, next state PAY.
- PAY (combinational pass-through):
  - m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready.
  - A 16-bit word counter increments per transfer.
  - m_axis_tlast=1 exactly on the L-th payload word.
  - On the tlast transfer: pkt_count increments mod 16 (15→0), pkt_total increments (wraps at 2^32), next state IDLE.
- Minimum one idle cycle between packets.
- Word counter and header registers are not affected by input changes mid-packet (stream_id, payload_len, enable, tsi, tsf).
- enable falling mid-packet: the packet completes normally; no new packet starts.
- tsi/tsf changing on the latch edge: the value present at the latch edge is used.
- m_axis_tvalid, once asserted on a header word, holds, and m_axis_tdata stays stable, until accepted (AXI-Stream rule).
- Latency: first sample available in IDLE → HDR word valid 1 cycle later. Sample 0 appears on m_axis after 5 accepted header words.
- No sample is dropped or duplicated. A sample is consumed only when s_axis_tvalid && s_axis_tready.

Test Plan:
- payload_len=4, stream_id=0xCAFE0001, tsi=0x100, tsf=0x200, m_axis_tready=1, samples 1..4 → words:
  - 0x1050_0009, 0xCAFE0001, 0x100, 0, 0x200, 1, 2, 3, 4.
  - tlast on word 4; pkt_count=1; pkt_total=1.
- Same packet with m_axis_tready toggled 1/0 each cycle and s_axis_tvalid gaps → identical word sequence; tdata stable while stalled; exactly 4 samples consumed.
- 17 back-to-back packets, payload_len=2 → header [19:16] runs 0..15 then 0; pkt_total=17.
- Length clamping:
  - payload_len=0 → size field 6, single payload word with tlast.
  - payload_len=0xFFFF → size field 0xFFFF; tlast on word 65530.
- Mid-packet changes:
  - tsi/tsf incremented every cycle → header carries the values at the latch edge only.
  - enable dropped at payload word 2 of 4 → packet completes with tlast; state stays IDLE afterwards.
- ARESETN low for 1 cycle during payload word 2 → next cycle m_axis_tvalid=0, pkt_count=0, pkt_total=0. Next packet starts cleanly with header pkt_count 0.
